// File: rtl/alu_regs_if.sv
// alu_regs_if: control/data bundle between the sequencer and the ALU operand
// register stage. The master side drives loads and stack controls; the slave
// side (alu_regs) returns the operand registers, stack status and flags.
interface alu_regs_if;
    logic [15:0] bus_in;
    logic [15:0] alu_res;
    logic        a_ld;
    logic        a_res;
    logic        b_ld;
    logic        swap;
    logic [4:0]  op_in;
    logic        op_ld;
    logic        push_b;
    logic        pop_b;
    logic        clr_err;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [4:0]  op_out;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
    logic        flag_z;
    logic        flag_n;

    modport master (
        output bus_in, alu_res, a_ld, a_res, b_ld, swap, op_in, op_ld,
               push_b, pop_b, clr_err,
        input  a_out, b_out, op_out, depth, ovf, unf, flag_z, flag_n
    );

    modport slave (
        input  bus_in, alu_res, a_ld, a_res, b_ld, swap, op_in, op_ld,
               push_b, pop_b, clr_err,
        output a_out, b_out, op_out, depth, ovf, unf, flag_z, flag_n
    );
endinterface

// File: rtl/alu_regs.sv
// alu_regs: A/B operand registers, latched opcode and a 4-entry LIFO for
// saving B. All state is registered on the rising edge so the ALU can settle
// on the falling edge. Optional result flags are built only when the macro
// ALU_REGS_FLAGS_EN is defined; otherwise flag_z/flag_n are tied low.
module alu_regs (
    input logic      clk,
    input logic      rst,
    alu_regs_if.slave regs
);
    logic [15:0] a_reg, a_next;
    logic [15:0] b_reg, b_next;
    logic [4:0]  op_reg;
    logic [2:0]  depth_reg, depth_next;
    logic        ovf_reg, unf_reg;
    logic [15:0] stack_mem [0:3];

    logic        push_only, pop_only;
    logic        do_push, do_pop;
    logic        ovf_set, unf_set;
    logic        swap_en;
    logic [15:0] stack_top;

    // Stack and swap qualification; push+pop together cancels out.
    always_comb begin
        push_only = regs.push_b & ~regs.pop_b;
        pop_only  = regs.pop_b & ~regs.push_b;
        do_push   = push_only & (depth_reg != 3'd4);
        do_pop    = pop_only & (depth_reg != 3'd0);
        ovf_set   = push_only & (depth_reg == 3'd4);
        unf_set   = pop_only & (depth_reg == 3'd0);
        // Any competing source on either register kills the whole swap.
        swap_en   = regs.swap & ~(regs.a_ld | regs.a_res | regs.b_ld | regs.pop_b);
        stack_top = stack_mem[depth_reg[1:0] - 2'd1];
    end

    // Next-value selection for A, B and depth.
    always_comb begin
        a_next = a_reg;
        if (regs.a_res)
            a_next = regs.alu_res;
        else if (regs.a_ld)
            a_next = regs.bus_in;
        else if (swap_en)
            a_next = b_reg;

        b_next = b_reg;
        if (regs.b_ld)
            b_next = regs.bus_in;
        else if (do_pop)
            b_next = stack_top;
        else if (swap_en)
            b_next = a_reg;

        depth_next = depth_reg;
        if (do_push)
            depth_next = depth_reg + 3'd1;
        else if (do_pop)
            depth_next = depth_reg - 3'd1;
    end

    // Register state with asynchronous active-low clear; errors are sticky, set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg     <= 16'h0000;
            b_reg     <= 16'h0000;
            op_reg    <= 5'h00;
            depth_reg <= 3'd0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            depth_reg <= depth_next;
            if (regs.op_ld)
                op_reg <= regs.op_in;
            if (ovf_set)
                ovf_reg <= 1'b1;
            else if (regs.clr_err)
                ovf_reg <= 1'b0;
            if (unf_set)
                unf_reg <= 1'b1;
            else if (regs.clr_err)
                unf_reg <= 1'b0;
        end
    end

    // Stack storage; contents are meaningless after reset since depth restarts at 0.
    always_ff @(posedge clk) begin
        if (do_push)
            stack_mem[depth_reg[1:0]] <= b_reg;
    end

`ifdef ALU_REGS_FLAGS_EN
    logic flag_z_reg, flag_n_reg;

    // Result flags track every write-back of the ALU result into A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
        end else if (regs.a_res) begin
            flag_z_reg <= (regs.alu_res == 16'h0000);
            flag_n_reg <= regs.alu_res[15];
        end
    end

    assign regs.flag_z = flag_z_reg;
    assign regs.flag_n = flag_n_reg;
`else
    assign regs.flag_z = 1'b0;
    assign regs.flag_n = 1'b0;
`endif

    assign regs.a_out  = a_reg;
    assign regs.b_out  = b_reg;
    assign regs.op_out = op_reg;
    assign regs.depth  = depth_reg;
    assign regs.ovf    = ovf_reg;
    assign regs.unf    = unf_reg;
endmodule

// File: tb/tb_alu_regs.sv
// tb_alu_regs: table-driven directed test for alu_regs, plus a hand-written
// asynchronous-reset sequence. Flag expectations follow ALU_REGS_FLAGS_EN.
module tb_alu_regs;
    localparam logic [7:0] C_ALD  = 8'h80;
    localparam logic [7:0] C_ARES = 8'h40;
    localparam logic [7:0] C_BLD  = 8'h20;
    localparam logic [7:0] C_SWP  = 8'h10;
    localparam logic [7:0] C_OPLD = 8'h08;
    localparam logic [7:0] C_PUSH = 8'h04;
    localparam logic [7:0] C_POP  = 8'h02;
    localparam logic [7:0] C_CLR  = 8'h01;
    localparam int NV = 40;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [15:0] bus;
        logic [15:0] res;
        logic [4:0]  opi;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [4:0]  eop;
        logic [2:0]  ed;
        logic        eovf;
        logic        eunf;
        logic        ez;
        logic        en;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs [NV];

    alu_regs_if rif ();

    alu_regs dut (
        .clk  (clk),
        .rst  (rst),
        .regs (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [7:0] ctl, logic [15:0] bus,
                                logic [15:0] res, logic [4:0] opi,
                                logic [15:0] ea, logic [15:0] eb, logic [4:0] eop,
                                logic [2:0] ed, logic eovf, logic eunf,
                                logic ez, logic en);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.bus = bus; v.res = res; v.opi = opi;
        v.ea = ea; v.eb = eb; v.eop = eop; v.ed = ed;
        v.eovf = eovf; v.eunf = eunf; v.ez = ez; v.en = en;
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic flag_exp(logic f);
`ifdef ALU_REGS_FLAGS_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    task automatic drive(logic [7:0] ctl, logic [15:0] bus, logic [15:0] res, logic [4:0] opi);
        rif.a_ld    = ctl[7];
        rif.a_res   = ctl[6];
        rif.b_ld    = ctl[5];
        rif.swap    = ctl[4];
        rif.op_ld   = ctl[3];
        rif.push_b  = ctl[2];
        rif.pop_b   = ctl[1];
        rif.clr_err = ctl[0];
        rif.bus_in  = bus;
        rif.alu_res = res;
        rif.op_in   = opi;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".a"},     rif.a_out, 16'h0000);
        chk({tag, ".b"},     rif.b_out, 16'h0000);
        chk({tag, ".op"},    {11'd0, rif.op_out}, 16'h0000);
        chk({tag, ".depth"}, {13'd0, rif.depth}, 16'h0000);
        chk({tag, ".ovf"},   {15'd0, rif.ovf}, 16'h0000);
        chk({tag, ".unf"},   {15'd0, rif.unf}, 16'h0000);
        chk({tag, ".z"},     {15'd0, rif.flag_z}, 16'h0000);
        chk({tag, ".n"},     {15'd0, rif.flag_n}, 16'h0000);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //           name        ctl               bus      res      opi    A        B        op     d  ov un z  n
        vecs[0]  = mk("load_a",   C_ALD|C_OPLD,    16'h0003,16'h0000,5'h00, 16'h0003,16'h0000,5'h00, 0, 0,0, 0,0);
        vecs[1]  = mk("load_b",   C_BLD,           16'h0004,16'h0000,5'h15, 16'h0003,16'h0004,5'h00, 0, 0,0, 0,0);
        vecs[2]  = mk("add_res",  C_ARES,          16'h0000,16'h0007,5'h15, 16'h0007,16'h0004,5'h00, 0, 0,0, 0,0);
        vecs[3]  = mk("swap",     C_SWP,           16'h0000,16'h0000,5'h15, 16'h0004,16'h0007,5'h00, 0, 0,0, 0,0);
        vecs[4]  = mk("push_op",  C_PUSH|C_OPLD,   16'h0000,16'h0000,5'h1F, 16'h0004,16'h0007,5'h1F, 1, 0,0, 0,0);
        vecs[5]  = mk("load_b55", C_BLD,           16'h5555,16'h0000,5'h15, 16'h0004,16'h5555,5'h1F, 1, 0,0, 0,0);
        vecs[6]  = mk("prio",     C_ARES|C_ALD|C_SWP,16'h2222,16'h1111,5'h15,16'h1111,16'h5555,5'h1F,1, 0,0, 0,0);
        vecs[7]  = mk("res_zero", C_ARES,          16'h0000,16'h0000,5'h15, 16'h0000,16'h5555,5'h1F, 1, 0,0, 1,0);
        vecs[8]  = mk("res_neg",  C_ARES,          16'h0000,16'h8001,5'h15, 16'h8001,16'h5555,5'h1F, 1, 0,0, 0,1);
        vecs[9]  = mk("lda_op",   C_ALD|C_OPLD,    16'h0000,16'h0000,5'h0A, 16'h0000,16'h5555,5'h0A, 1, 0,0, 0,1);
        vecs[10] = mk("swap2",    C_SWP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0000,5'h0A, 1, 0,0, 0,1);
        vecs[11] = mk("pop_7",    C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0007,5'h0A, 0, 0,0, 0,1);
        vecs[12] = mk("ldb_1",    C_BLD,           16'h0001,16'h0000,5'h15, 16'h5555,16'h0001,5'h0A, 0, 0,0, 0,1);
        vecs[13] = mk("push_1",   C_PUSH|C_BLD,    16'h0002,16'h0000,5'h15, 16'h5555,16'h0002,5'h0A, 1, 0,0, 0,1);
        vecs[14] = mk("push_2",   C_PUSH|C_BLD,    16'h0003,16'h0000,5'h15, 16'h5555,16'h0003,5'h0A, 2, 0,0, 0,1);
        vecs[15] = mk("push_3",   C_PUSH|C_BLD,    16'h0004,16'h0000,5'h15, 16'h5555,16'h0004,5'h0A, 3, 0,0, 0,1);
        vecs[16] = mk("push_4",   C_PUSH,          16'h0000,16'h0000,5'h15, 16'h5555,16'h0004,5'h0A, 4, 0,0, 0,1);
        vecs[17] = mk("push_ovf", C_PUSH,          16'h0000,16'h0000,5'h15, 16'h5555,16'h0004,5'h0A, 4, 1,0, 0,1);
        vecs[18] = mk("ldb_0",    C_BLD,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0000,5'h0A, 4, 1,0, 0,1);
        vecs[19] = mk("pop_4",    C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0004,5'h0A, 3, 1,0, 0,1);
        vecs[20] = mk("pop_3",    C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0003,5'h0A, 2, 1,0, 0,1);
        vecs[21] = mk("pop_2",    C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0002,5'h0A, 1, 1,0, 0,1);
        vecs[22] = mk("pop_1",    C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0001,5'h0A, 0, 1,0, 0,1);
        vecs[23] = mk("clr_ovf",  C_CLR,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0001,5'h0A, 0, 0,0, 0,1);
        vecs[24] = mk("ldb_aa",   C_BLD,           16'h00AA,16'h0000,5'h15, 16'h5555,16'h00AA,5'h0A, 0, 0,0, 0,1);
        vecs[25] = mk("pop_unf",  C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h00AA,5'h0A, 0, 0,1, 0,1);
        vecs[26] = mk("clr_unf",  C_CLR,           16'h0000,16'h0000,5'h15, 16'h5555,16'h00AA,5'h0A, 0, 0,0, 0,1);
        vecs[27] = mk("clr_set",  C_CLR|C_POP,     16'h0000,16'h0000,5'h15, 16'h5555,16'h00AA,5'h0A, 0, 0,1, 0,1);
        vecs[28] = mk("unf_ldb",  C_POP|C_BLD,     16'h00BB,16'h0000,5'h15, 16'h5555,16'h00BB,5'h0A, 0, 0,1, 0,1);
        vecs[29] = mk("clr_2",    C_CLR,           16'h0000,16'h0000,5'h15, 16'h5555,16'h00BB,5'h0A, 0, 0,0, 0,1);
        vecs[30] = mk("push_bb",  C_PUSH,          16'h0000,16'h0000,5'h15, 16'h5555,16'h00BB,5'h0A, 1, 0,0, 0,1);
        vecs[31] = mk("push_ld8", C_PUSH|C_BLD,    16'h0008,16'h0000,5'h15, 16'h5555,16'h0008,5'h0A, 2, 0,0, 0,1);
        vecs[32] = mk("pushpop",  C_PUSH|C_POP,    16'h0000,16'h0000,5'h15, 16'h5555,16'h0008,5'h0A, 2, 0,0, 0,1);
        vecs[33] = mk("pp_swap",  C_PUSH|C_POP|C_SWP,16'h0000,16'h0000,5'h15,16'h5555,16'h0008,5'h0A,2, 0,0, 0,1);
        vecs[34] = mk("push_ld9", C_PUSH|C_BLD,    16'h0009,16'h0000,5'h15, 16'h5555,16'h0009,5'h0A, 3, 0,0, 0,1);
        vecs[35] = mk("pop_top8", C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h0008,5'h0A, 2, 0,0, 0,1);
        vecs[36] = mk("pop_ldc",  C_POP|C_BLD,     16'h000C,16'h0000,5'h15, 16'h5555,16'h000C,5'h0A, 1, 0,0, 0,1);
        vecs[37] = mk("pop_bb",   C_POP,           16'h0000,16'h0000,5'h15, 16'h5555,16'h00BB,5'h0A, 0, 0,0, 0,1);
        vecs[38] = mk("pp_empty", C_PUSH|C_POP,    16'h0000,16'h0000,5'h15, 16'h5555,16'h00BB,5'h0A, 0, 0,0, 0,1);
        vecs[39] = mk("push_swp", C_PUSH|C_SWP,    16'h0000,16'h0000,5'h15, 16'h00BB,16'h5555,5'h0A, 1, 0,0, 0,1);

        // Reset: create a real falling edge so the asynchronous clear fires.
        drive(8'h00, 16'h0000, 16'h0000, 5'h00);
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 chk_reset("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_reset("rst_held");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].bus, vecs[i].res, vecs[i].opi);
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".a"},     rif.a_out, vecs[i].ea);
            chk({vecs[i].name, ".b"},     rif.b_out, vecs[i].eb);
            chk({vecs[i].name, ".op"},    {11'd0, rif.op_out}, {11'd0, vecs[i].eop});
            chk({vecs[i].name, ".depth"}, {13'd0, rif.depth}, {13'd0, vecs[i].ed});
            chk({vecs[i].name, ".ovf"},   {15'd0, rif.ovf}, {15'd0, vecs[i].eovf});
            chk({vecs[i].name, ".unf"},   {15'd0, rif.unf}, {15'd0, vecs[i].eunf});
            chk({vecs[i].name, ".z"},     {15'd0, rif.flag_z}, {15'd0, flag_exp(vecs[i].ez)});
            chk({vecs[i].name, ".n"},     {15'd0, rif.flag_n}, {15'd0, flag_exp(vecs[i].en)});
            $display("vec %0d %s: a=%h b=%h op=%h depth=%0d ovf=%b unf=%b z=%b n=%b",
                     i, vecs[i].name, rif.a_out, rif.b_out, rif.op_out, rif.depth,
                     rif.ovf, rif.unf, rif.flag_z, rif.flag_n);
        end

        // Mid-cycle asynchronous reset with A, B, depth all nonzero.
        @(negedge clk);
        drive(C_PUSH, 16'h0000, 16'h0000, 5'h15);
        @(posedge clk);
        #1;
        chk("pre_rst.depth", {13'd0, rif.depth}, 16'h0002);
        #2 rst = 1'b0;
        #1 chk_reset("rst_mid");
        $display("mid-cycle reset: a=%h b=%h depth=%0d", rif.a_out, rif.b_out, rif.depth);
        @(negedge clk);
        drive(8'h00, 16'h0000, 16'h0000, 5'h00);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_reset("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
